gpio_uart_tx: RTL and testbench

Buffered UART transmitter that consumes the byte/strobe pair produced by the GPIO push-button capture stage (`out_data`/`out_ready`) and serialises each byte onto the board TX pin. It sits directly downstream of the GPIO block. A small FIFO absorbs bursts, because the capture stage has no backpressure. Frames are 8N1 by default, with optional even parity.

---
 rtl/gpio_uart_pkg.sv | 17 +
 rtl/gpio_tx_fifo.sv | 46 ++++
 rtl/gpio_uart_tx.sv | 135 +++++++++++++
 tb/tb_gpio_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-fed UART transmitter.
// The optional even-parity bit is enabled with the GPIO_UART_PARITY_EN macro.
package gpio_uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 868;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/gpio_tx_fifo.sv
// Synchronous byte FIFO buffering GPIO capture strobes ahead of the UART FSM.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module gpio_tx_fifo
    import gpio_uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [PW-1:0]        o_count
);

    localparam int unsigned AW = PW - 1;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_count = r_wptr - r_rptr;
    assign o_full  = (o_count == PW'(DEPTH));
    assign o_empty = (o_count == '0);

endmodule

// File: rtl/gpio_uart_tx.sv
// Buffered UART transmitter (8N1) fed by the GPIO capture stage's byte/strobe pair.
// Define GPIO_UART_PARITY_EN to insert an even-parity bit after the data bits.
module gpio_uart_tx
    import gpio_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         tx,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            r_state, w_state_d;
    logic [BAUD_W-1:0]    r_baud, w_baud_d;
    logic [BIT_W-1:0]     r_bit, w_bit_d;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_tx, w_tx_d;
    logic                 r_overflow;

    logic                 w_push, w_pop, w_full, w_empty, w_baud_last;
    logic [DATA_BITS-1:0] w_rdata;
    logic [CNT_W-1:0]     w_count;

    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    assign w_push      = in_valid & (~w_full | w_pop);
    assign w_baud_last = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    gpio_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_d = r_state;
        w_baud_d  = r_baud + BAUD_W'(1);
        w_bit_d   = r_bit;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = START;
                end
            end
            START: begin
                if (w_baud_last) w_state_d = DATA;
            end
            DATA: begin
                if (w_baud_last) begin
                    w_bit_d = r_bit + BIT_W'(1);
                    if (r_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef GPIO_UART_PARITY_EN
                        w_state_d = PARITY;
`else
                        w_state_d = STOP;
`endif
                    end
                end
            end
`ifdef GPIO_UART_PARITY_EN
            PARITY: begin
                if (w_baud_last) w_state_d = STOP;
            end
`endif
            STOP: begin
                if (w_baud_last) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = START;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
        if (w_baud_last || (w_state_d != r_state) || (r_state == IDLE)) w_baud_d = '0;
    end

    // The line level is registered, so it trails the FSM state by one cycle.
    always_comb begin
        w_tx_d = 1'b1;
        case (r_state)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = r_data[r_bit];
`ifdef GPIO_UART_PARITY_EN
            PARITY:  w_tx_d = ^r_data;
`endif
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_baud     <= w_baud_d;
            r_bit      <= w_bit_d;
            r_tx       <= w_tx_d;
            r_overflow <= in_valid & w_full & ~w_pop;
            if (w_pop) r_data <= w_rdata;
        end
    end

    assign tx         = r_tx;
    assign overflow   = r_overflow;
    assign fifo_count = w_count;
    assign busy       = (r_state != IDLE) | (w_count != '0);

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx (CLKS_PER_BIT = 4, FIFO_DEPTH = 4) with a line receiver model.
// Parity checks are compiled in when GPIO_UART_PARITY_EN is defined.
module tb_gpio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef GPIO_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fails = 0;

    logic [7:0]  rx_bytes[$];
    int unsigned rx_start[$];
    logic        rx_ok[$];
    logic        rx_par[$];
    int unsigned busy_cycles = 0;
    int unsigned ovf_pulses = 0;
    int unsigned peak_count = 0;

    gpio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Receiver: samples mid-bit on the falling edge, aborts on reset.
    initial begin : mon
        bit          active;
        int unsigned cnt, idx, st;
        logic [7:0]  sh;
        logic        ok, par;
        active = 1'b0;
        cnt = 0; st = 0; sh = '0; ok = 1'b1; par = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (overflow) ovf_pulses++;
            if (fifo_count > peak_count) peak_count = fifo_count;
            if (!rstn) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx == 1'b0) begin
                    active = 1'b1; cnt = 0; st = cyc; sh = '0; ok = 1'b1; par = 1'b0;
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2) begin
                    idx = cnt / CPB;
                    if (idx >= 1 && idx <= 8) sh[idx-1] = tx;
                    else if (idx == NBITS - 1) ok = ok & (tx == 1'b1);
                    else begin
                        par = tx;
                        ok  = ok & (tx == ^sh);
                    end
                end
                if (cnt == CPB / 2) ok = ok & (tx == 1'b0);
                if (cnt == FRAME - 1) begin
                    rx_bytes.push_back(sh);
                    rx_start.push_back(st);
                    rx_ok.push_back(ok);
                    rx_par.push_back(par);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output int unsigned edge_cyc);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hFF;
        edge_cyc = cyc;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (rx_bytes.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("frames_rx", rx_bytes.size(), n);
    endtask

    task automatic wait_idle(input int unsigned budget);
        int unsigned k = 0;
        while ((busy || !tx) && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_busy", busy, 1'b0);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
        rx_ok.delete();
        rx_par.delete();
    endtask

    initial begin : main
        int unsigned p, q;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_count", fifo_count, 3'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte: latency, bit pattern, busy width
        clear_rx();
        busy_cycles = 0;
        push(8'hA5, p);
        check_eq("a5_count", fifo_count, 3'd1);
        @(posedge clk); #1;
        check_eq("a5_tx_n1", tx, 1'b1);
        @(posedge clk); #1;
        check_eq("a5_tx_n2", tx, 1'b0);
        wait_frames(1, 200);
        check_eq("a5_byte", rx_bytes[0], 8'hA5);
        check_eq("a5_frame_ok", rx_ok[0], 1'b1);
        check_eq("a5_start_cyc", rx_start[0], p + 2);
        wait_idle(100);
        check_eq("a5_busy_cycles", busy_cycles, 41);
        check_eq("a5_junk_ignored", fifo_count, 3'd0);

        // Four back-to-back bytes: contiguous frames
        clear_rx();
        peak_count = 0;
        ovf_pulses = 0;
        push(8'h01, p);
        for (int i = 2; i <= 4; i++) push(8'(i), q);
        wait_frames(4, 400);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("b2b_byte%0d", i), rx_bytes[i], 8'(i + 1));
            check_eq($sformatf("b2b_ok%0d", i), rx_ok[i], 1'b1);
            if (i > 0) check_eq($sformatf("b2b_gap%0d", i), rx_start[i] - rx_start[i-1], FRAME);
        end
        check_eq("b2b_start_cyc", rx_start[0], p + 2);
        check_eq("b2b_peak", peak_count, 3);
        wait_idle(100);
        check_eq("b2b_no_ovf", ovf_pulses, 0);

        // Six pushes into a four-deep FIFO: one dropped
        clear_rx();
        peak_count = 0;
        ovf_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            push(8'(8'h10 + i), q);
            if (i == 5) check_eq("ovf_pulse_hi", overflow, 1'b1);
        end
        @(posedge clk); #1;
        check_eq("ovf_pulse_lo", overflow, 1'b0);
        wait_frames(5, 600);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("ovf_byte%0d", i), rx_bytes[i], 8'(8'h10 + i));
            check_eq($sformatf("ovf_ok%0d", i), rx_ok[i], 1'b1);
        end
        wait_idle(200);
        check_eq("ovf_pulses", ovf_pulses, 1);
        check_eq("ovf_peak", peak_count, 4);
        check_eq("ovf_dropped", rx_bytes.size(), 5);

`ifdef GPIO_UART_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0, 11-bit frames
        clear_rx();
        push(8'h07, p);
        push(8'h03, q);
        wait_frames(2, 300);
        check_eq("par_byte0", rx_bytes[0], 8'h07);
        check_eq("par_bit0", rx_par[0], 1'b1);
        check_eq("par_byte1", rx_bytes[1], 8'h03);
        check_eq("par_bit1", rx_par[1], 1'b0);
        check_eq("par_frame_len", rx_start[1] - rx_start[0], 44);
        check_eq("par_ok", rx_ok[0] & rx_ok[1], 1'b1);
        wait_idle(100);
`endif

        // Reset during data bit 3 of 0x5A with two bytes queued
        clear_rx();
        push(8'h5A, p);
        push(8'h11, q);
        push(8'h22, q);
        repeat (15) @(posedge clk);
        #1;
        check_eq("mid_count", fifo_count, 3'd2);
        check_eq("mid_tx_bit2", tx, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check_eq("mid_rst_tx", tx, 1'b1);
        check_eq("mid_rst_count", fifo_count, 3'd0);
        check_eq("mid_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk); #1;
        check_eq("mid_rst_quiet", tx, 1'b1);
        clear_rx();
        push(8'h3C, p);
        wait_frames(1, 200);
        check_eq("post_rst_byte", rx_bytes[0], 8'h3C);
        check_eq("post_rst_ok", rx_ok[0], 1'b1);
        check_eq("post_rst_start", rx_start[0], p + 2);
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
